// File: rtl/value_narrower_pkg.sv
// Shared types and sizing helpers for the value narrower.
package value_narrower_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } narrower_state_t;

  // Number of CHUNK_WIDTH-bit chunks needed to cover a data_width-bit value.
  function automatic int num_chunks(input int data_width, input int chunk_width);
    return (data_width + chunk_width - 32'sd1) / chunk_width;
  endfunction

  // Width of the chunk-count output: must represent 0..num_chunks.
  function automatic int len_width(input int data_width, input int chunk_width);
    return $clog2(num_chunks(data_width, chunk_width) + 32'sd1);
  endfunction

  // Width of the chunk index: must represent 0..num_chunks-1, at least one bit.
  function automatic int cnt_width(input int data_width, input int chunk_width);
    int nc;
    nc = num_chunks(data_width, chunk_width);
    return (nc > 32'sd1) ? $clog2(nc) : 32'sd1;
  endfunction

  localparam int DEFAULT_LEN_W = len_width(32'sd8, 32'sd3);

endpackage

// File: rtl/imm_extender.sv
// Immediate extender: widens INPUT_WIDTH bits to DATA_WIDTH bits by sign or zero extension.
module imm_extender #(
  parameter int INPUT_WIDTH = 3,
  parameter int DATA_WIDTH  = 9
) (
  input  logic [INPUT_WIDTH-1:0] imm_in,
  input  logic                   is_sign_ext,
  output logic [DATA_WIDTH-1:0]  imm_out
);

  // Copy the low bits, then fill the upper bits with ones for a negative signed input.
  always_comb begin
    imm_out = {DATA_WIDTH{1'b0}};
    imm_out[INPUT_WIDTH-1:0] = imm_in;
    if (is_sign_ext && imm_in[INPUT_WIDTH-1]) begin
      imm_out = imm_out | ({DATA_WIDTH{1'b1}} << INPUT_WIDTH);
    end else begin
      imm_out = imm_out;
    end
  end

endmodule

// File: rtl/value_narrower_chunk_fit_calc.sv
// Combinational padding of the input value and search for the fewest chunks
// that an extender-based receiver can rebuild it from.
module value_narrower_chunk_fit_calc
  import value_narrower_pkg::*;
#(
  parameter int CHUNK_WIDTH = 3,
  parameter int DATA_WIDTH  = 8
) (
  input  logic [DATA_WIDTH-1:0]                                    in_val,
  input  logic                                                     is_sign_ext,
  output logic [num_chunks(DATA_WIDTH, CHUNK_WIDTH)*CHUNK_WIDTH-1:0] padded,
  output logic [len_width(DATA_WIDTH, CHUNK_WIDTH)-1:0]            n_chunks
);

  localparam int NC    = num_chunks(DATA_WIDTH, CHUNK_WIDTH);
  localparam int PW    = NC * CHUNK_WIDTH;
  localparam int LEN_W = len_width(DATA_WIDTH, CHUNK_WIDTH);

  logic [NC-1:0] fits_s;

  // The padded value is simply the input run through the same extender the receiver uses.
  imm_extender #(
    .INPUT_WIDTH (DATA_WIDTH),
    .DATA_WIDTH  (PW)
  ) u_pad (
    .imm_in      (in_val),
    .is_sign_ext (is_sign_ext),
    .imm_out     (padded)
  );

  // Candidate k keeps the low k chunks; it fits if re-extending them restores the padded value.
  for (genvar k = 1; k <= NC; k++) begin : g_cand
    logic [PW-1:0] rebuilt_s;

    imm_extender #(
      .INPUT_WIDTH (k * CHUNK_WIDTH),
      .DATA_WIDTH  (PW)
    ) u_ext (
      .imm_in      (padded[k*CHUNK_WIDTH-1:0]),
      .is_sign_ext (is_sign_ext),
      .imm_out     (rebuilt_s)
    );

    assign fits_s[k-1] = (rebuilt_s == padded);
  end

  // Priority select of the smallest fitting k; the full width always fits.
  always_comb begin
    n_chunks = LEN_W'(NC);
    for (int k = NC; k >= 1; k--) begin
      if (fits_s[k-1]) begin
        n_chunks = LEN_W'(k);
      end else begin
        n_chunks = n_chunks;
      end
    end
  end

endmodule

// File: rtl/value_narrower.sv
// Value narrower: encodes a wide value as the minimum number of chunks and
// streams them most-significant first over a valid/ready handshake.
module value_narrower
  import value_narrower_pkg::*;
#(
  parameter int CHUNK_WIDTH = 3,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          in_valid,
  input  logic [DATA_WIDTH-1:0]                         in_val,
  input  logic                                          is_sign_ext,
  output logic                                          in_ready,
  output logic                                          out_valid,
  output logic [CHUNK_WIDTH-1:0]                        out_chunk,
  output logic                                          out_last,
  output logic [len_width(DATA_WIDTH, CHUNK_WIDTH)-1:0] out_len,
  input  logic                                          out_ready
);

  localparam int NC    = num_chunks(DATA_WIDTH, CHUNK_WIDTH);
  localparam int PW    = NC * CHUNK_WIDTH;
  localparam int LEN_W = len_width(DATA_WIDTH, CHUNK_WIDTH);
  localparam int CNT_W = cnt_width(DATA_WIDTH, CHUNK_WIDTH);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  narrower_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    padded_q, padded_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic [PW-1:0]    fit_padded_s;
  logic [LEN_W-1:0] fit_len_s;
  logic             accept_s;

  value_narrower_chunk_fit_calc #(
    .CHUNK_WIDTH (CHUNK_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_fit (
    .in_val      (in_val),
    .is_sign_ext (is_sign_ext),
    .padded      (fit_padded_s),
    .n_chunks    (fit_len_s)
  );

  // Handshake outputs decoded from the state register; in_ready is held low during reset.
  always_comb begin
    in_ready  = (state_q == IDLE) && !reset;
    accept_s  = in_valid && in_ready;
    out_valid = (state_q == SEND);
    out_last  = (state_q == SEND) && (cnt_q == {CNT_W{1'b0}});
    out_len   = len_q;
  end

  // Select the current chunk from the latched value; it naturally holds after the last beat.
  always_comb begin
    int idx;
    idx       = int'(cnt_q) * CHUNK_WIDTH;
    out_chunk = padded_q[idx +: CHUNK_WIDTH];
  end

  // Next-state logic: latch on accept, count chunks down on each taken beat.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    padded_d = padded_q;
    len_d    = len_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          padded_d = fit_padded_s;
          len_d    = fit_len_s;
          cnt_d    = CNT_W'(fit_len_s - LEN_ONE);
          state_d  = SEND;
        end else begin
          state_d  = IDLE;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q - CNT_ONE;
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, chunk index, latched value and length registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      padded_q <= {PW{1'b0}};
      len_q    <= {LEN_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      padded_q <= padded_d;
      len_q    <= len_d;
    end
  end

endmodule

// File: tb/tb_value_narrower.sv
// Directed and scoreboarded bench for value_narrower (DATA_WIDTH=8, CHUNK_WIDTH=3).
module tb_value_narrower;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_val;
  logic       is_sign_ext;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] out_chunk;
  logic       out_last;
  logic [1:0] out_len;
  logic       out_ready;

  int checks   = 0;
  int failures = 0;

  value_narrower #(.CHUNK_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_val      (in_val),
    .is_sign_ext (is_sign_ext),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_chunk   (out_chunk),
    .out_last    (out_last),
    .out_len     (out_len),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent model: smallest k whose k*3-bit range holds the value.
  function automatic int model_n(input logic [7:0] v, input logic s);
    int w;
    int sv;
    sv = int'($signed(v));
    for (int k = 1; k <= 3; k++) begin
      w = 3 * k;
      if (s) begin
        if (sv >= -(1 << (w - 1)) && sv <= (1 << (w - 1)) - 1) return k;
      end else begin
        if (int'(v) < (1 << w)) return k;
      end
    end
    return 3;
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_val = 8'h00; is_sign_ext = 1'b0; out_ready = 1'b0;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_chunk !== 3'b000) begin failures++; $display("FAIL reset_out_chunk got=%b exp=000", out_chunk); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%0b exp=0", out_last); end
    checks++; if (out_len !== 2'd0) begin failures++; $display("FAIL reset_out_len got=%0d exp=0", out_len); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%0b exp=1", in_ready); end
  endtask

  // Accept one value and drain it with out_ready held high, checking every beat.
  task automatic run_stream(input string name, input logic [7:0] v, input logic s,
                            input int n, input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2);
    logic [2:0] exp_c [3];
    exp_c[0] = c0; exp_c[1] = c1; exp_c[2] = c2;
    out_ready = 1'b1;
    in_val = v; is_sign_ext = s; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_val = ~v; is_sign_ext = ~s;
    for (int i = 0; i < n; i++) begin
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL %s_valid beat=%0d got=%0b exp=1", name, i, out_valid); end
      checks++; if (out_chunk !== exp_c[i]) begin failures++; $display("FAIL %s_chunk beat=%0d got=%b exp=%b", name, i, out_chunk, exp_c[i]); end
      checks++; if (out_last !== (i == n - 1)) begin failures++; $display("FAIL %s_last beat=%0d got=%0b exp=%0b", name, i, out_last, (i == n - 1)); end
      checks++; if (out_len !== 2'(n)) begin failures++; $display("FAIL %s_len beat=%0d got=%0d exp=%0d", name, i, out_len, n); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL %s_in_ready beat=%0d got=%0b exp=0", name, i, in_ready); end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_done_valid got=%0b exp=0", name, out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL %s_done_ready got=%0b exp=1", name, in_ready); end
    checks++; if (out_chunk !== exp_c[n-1]) begin failures++; $display("FAIL %s_hold_chunk got=%b exp=%b", name, out_chunk, exp_c[n-1]); end
    checks++; if (out_len !== 2'(n)) begin failures++; $display("FAIL %s_hold_len got=%0d exp=%0d", name, out_len, n); end
  endtask

  task automatic test_single_beat();
    run_stream("fe_sign", 8'hFE, 1'b1, 1, 3'b110, 3'b000, 3'b000);
    run_stream("05_zero", 8'h05, 1'b0, 1, 3'b101, 3'b000, 3'b000);
  endtask

  task automatic test_multi_beat();
    run_stream("fe_zero", 8'hFE, 1'b0, 3, 3'b011, 3'b111, 3'b110);
    run_stream("05_sign", 8'h05, 1'b1, 2, 3'b000, 3'b101, 3'b000);
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_val = 8'h80; is_sign_ext = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_chunk !== 3'b110 || out_valid !== 1'b1) begin failures++; $display("FAIL stall_beat1 got=%b/%0b exp=110/1", out_chunk, out_valid); end
    checks++; if (out_len !== 2'd3) begin failures++; $display("FAIL stall_len got=%0d exp=3", out_len); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b1; in_val = 8'h55; is_sign_ext = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (out_chunk !== 3'b000) begin failures++; $display("FAIL stall_chunk cyc=%0d got=%b exp=000", i, out_chunk); end
      checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL stall_last cyc=%0d got=%0b exp=0", i, out_last); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid cyc=%0d got=%0b exp=1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%0b exp=0", i, in_ready); end
      checks++; if (out_len !== 2'd3) begin failures++; $display("FAIL stall_len_hold cyc=%0d got=%0d exp=3", i, out_len); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if (out_chunk !== 3'b000 || out_last !== 1'b1) begin failures++; $display("FAIL stall_beat3 got=%b/%0b exp=000/1", out_chunk, out_last); end
    step();
    checks++; if (out_valid !== 1'b0 || out_len !== 2'd3) begin failures++; $display("FAIL stall_end got=%0b/%0d exp=0/3", out_valid, out_len); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    in_val = 8'h80; is_sign_ext = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_last !== 1'b0) begin failures++; $display("FAIL mid_beat2 got=%0b/%0b exp=1/0", out_valid, out_last); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%0b exp=1", in_ready); end
    checks++; if (out_len !== 2'd0) begin failures++; $display("FAIL mid_reset_len got=%0d exp=0", out_len); end
    run_stream("zero_after_reset", 8'h00, 1'b0, 1, 3'b000, 3'b000, 3'b000);
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    logic       s;
    logic       full_rate;
    int n_exp, exp_val, acc, beats, cycles, guard, len_seen;
    logic done;
    for (int t = 0; t < 40; t++) begin
      v = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      full_rate = (t < 20);
      n_exp = model_n(v, s);
      exp_val = s ? int'($signed(v)) : int'(v);
      in_val = v; is_sign_ext = s; in_valid = 1'b1;
      guard = 0;
      while (in_ready !== 1'b1 && guard < 50) begin
        out_ready = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
        step();
        guard++;
      end
      checks++; if (guard >= 50) begin failures++; $display("FAIL b2b_wait_ready t=%0d got=timeout exp=in_ready", t); end
      step();
      cycles = 1; beats = 0; acc = 0; len_seen = -1; done = 1'b0; guard = 0;
      while (!done && guard < 100) begin
        out_ready = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (beats == 0) begin
            len_seen = int'(out_len);
            acc = s ? int'($signed(out_chunk)) : int'(out_chunk);
          end else begin
            acc = (acc <<< 3) | int'(out_chunk);
          end
          beats++;
          if (out_last === 1'b1) done = 1'b1;
        end
        step();
        cycles++;
        guard++;
      end
      checks++; if (!done) begin failures++; $display("FAIL b2b_drain t=%0d got=timeout exp=last_beat", t); end
      checks++; if (acc !== exp_val) begin failures++; $display("FAIL b2b_rebuild t=%0d v=%h s=%0b got=%0d exp=%0d", t, v, s, acc, exp_val); end
      checks++; if (len_seen !== n_exp) begin failures++; $display("FAIL b2b_len t=%0d v=%h s=%0b got=%0d exp=%0d", t, v, s, len_seen, n_exp); end
      checks++; if (beats !== n_exp) begin failures++; $display("FAIL b2b_beats t=%0d got=%0d exp=%0d", t, beats, n_exp); end
      if (full_rate) begin
        checks++; if (cycles !== n_exp + 1) begin failures++; $display("FAIL b2b_cycles t=%0d got=%0d exp=%0d", t, cycles, n_exp + 1); end
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_stall();
    test_reset_midstream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
